// File: rtl/memtest_seq.sv
// Pass sequencer for the SDRAM memory tester: writes the generator sequence over the
// whole address range, rewinds the generator, reads back and counts mismatches.
module memtest_seq #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int INIT_CYCLES = 4,
  parameter int ERR_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              gen_init,
  output logic              gen_save,
  output logic              gen_restore,
  output logic              gen_next,
  input  logic [DATA_W-1:0] gen_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              phase,
  output logic [15:0]       pass_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  output logic [2:0]        dbg_state_o
);

  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SAVE, S_WR, S_WR_NEXT, S_RESTORE, S_RD, S_RD_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [ICW-1:0]    init_cnt_q, init_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic [15:0]       pass_cnt_q, pass_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              err_flag_q, err_flag_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      init_cnt_q <= '0;
      addr_q     <= '0;
      phase_q    <= 1'b0;
      pass_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      addr_q     <= addr_d;
      phase_q    <= phase_d;
      pass_cnt_q <= pass_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Handshake: a request state holds mem_req with stable address/data until the
  // one-cycle mem_ack; the following strobe state always has mem_req low.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    addr_d     = addr_q;
    phase_d    = phase_q;
    pass_cnt_d = pass_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          pass_cnt_d = '0;
          err_cnt_d  = '0;
          err_flag_d = 1'b0;
          err_addr_d = '0;
          addr_d     = '0;
          init_cnt_d = '0;
          state_d    = S_INIT;
        end
      end
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) state_d = S_SAVE;
        else init_cnt_d = init_cnt_q + 1'b1;
      end
      S_SAVE: begin
        phase_d = 1'b0;
        state_d = S_WR;
      end
      S_WR: begin
        if (mem_ack) state_d = S_WR_NEXT;
      end
      S_WR_NEXT: begin
        if (addr_q == '1) begin
          addr_d  = '0;
          state_d = S_RESTORE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_WR;
        end
      end
      S_RESTORE: begin
        phase_d = 1'b1;
        state_d = S_RD;
      end
      S_RD: begin
        if (mem_ack) begin
          if (mem_rdata != gen_out) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (!err_flag_q) begin
              err_flag_d = 1'b1;
              err_addr_d = addr_q;
            end
          end
          state_d = S_RD_NEXT;
        end
      end
      S_RD_NEXT: begin
        if (addr_q != '1) begin
          addr_d  = addr_q + 1'b1;
          state_d = S_RD;
        end else begin
          // Passes chain without re-init so the generator sequence keeps advancing.
          pass_cnt_d = pass_cnt_q + 1'b1;
          addr_d     = '0;
          state_d    = enable ? S_SAVE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gen_init    = (state_q == S_INIT);
  assign gen_save    = (state_q == S_SAVE);
  assign gen_restore = (state_q == S_RESTORE);
  assign gen_next    = (state_q == S_WR_NEXT) || (state_q == S_RD_NEXT);
  assign mem_req     = (state_q == S_WR) || (state_q == S_RD);
  assign mem_we      = (state_q == S_WR);
  assign mem_addr    = addr_q;
  // Gated so the write bus reads zero whenever no write is being presented.
  assign mem_wdata   = (state_q == S_WR) ? gen_out : '0;
  assign busy        = (state_q != S_IDLE);
  assign phase       = phase_q;
  assign pass_cnt    = pass_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign err_flag    = err_flag_q;
  assign err_addr    = err_addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_memtest_seq.sv
// Directed bench for memtest_seq with a behavioural pattern generator and memory
// model whose acknowledge latency can be zero, random or held off.
module tb_memtest_seq;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 16;
  localparam int INIT_CYCLES = 4;
  localparam int ERR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              gen_init, gen_save, gen_restore, gen_next;
  logic [DATA_W-1:0] gen_out;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr, err_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy, phase, err_flag;
  logic [15:0]       pass_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic [2:0]        dbg_state;

  memtest_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_CYCLES(INIT_CYCLES), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .gen_init(gen_init), .gen_save(gen_save), .gen_restore(gen_restore), .gen_next(gen_next),
    .gen_out(gen_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .phase(phase), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
    .err_flag(err_flag), .err_addr(err_addr), .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // generator model: +36653 then rotate right by one
  logic [DATA_W-1:0] gen_q = '0, saved_q = '0, sum_w;
  assign sum_w   = gen_q + 16'd36653;
  assign gen_out = gen_q;
  always @(posedge clk) begin
    if (gen_init) gen_q <= '0;
    else if (gen_save) saved_q <= gen_q;
    else if (gen_restore) gen_q <= saved_q;
    else if (gen_next) gen_q <= {sum_w[0], sum_w[DATA_W-1:1]};
  end

  // memory model with configurable acknowledge latency
  logic [DATA_W-1:0] mem_arr [4];
  logic [3:0]        corrupt_mask = 4'b0000;
  logic              rand_en = 1'b0, ack_hold = 1'b0;
  int                ack_cnt = 0, cur_delay = 0;
  assign mem_ack   = mem_req && !ack_hold && (ack_cnt >= cur_delay);
  assign mem_rdata = mem_arr[mem_addr] ^ {15'd0, corrupt_mask[mem_addr]};
  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      ack_cnt   <= 0;
      cur_delay <= rand_en ? int'($urandom_range(0, 5)) : 0;
    end else if (mem_req) ack_cnt <= ack_cnt + 1;
    else ack_cnt <= 0;
  end

  // protocol monitors (cumulative)
  int unsigned       stab_viol = 0, overlap = 0, n_acks = 0, n_nexts = 0, n_init = 0;
  logic [DATA_W-1:0] wr_data_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic              in_req = 1'b0;
  logic [ADDR_W+DATA_W:0] held = '0;
  always @(negedge clk) begin
    if (!rst_n) in_req = 1'b0;
    else begin
      if (mem_req) begin
        if (in_req && ({mem_addr, mem_we, mem_wdata} != held)) stab_viol++;
        held   = {mem_addr, mem_we, mem_wdata};
        in_req = !mem_ack;
        if (mem_ack) begin
          n_acks++;
          if (mem_we) begin
            wr_data_q.push_back(mem_wdata);
            wr_addr_q.push_back(mem_addr);
          end
        end
      end else in_req = 1'b0;
      if ((int'(gen_init) + int'(gen_save) + int'(gen_restore) + int'(gen_next)) > 1) overlap++;
      if (gen_next) n_nexts++;
      if (gen_init) n_init++;
    end
  end

  // scoreboard
  int n_checks = 0, n_fail = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 400) begin @(posedge clk); #1; k++; end
    check_eq({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_pass(input logic [15:0] n, input string tag);
    int k = 0;
    while (pass_cnt != n && k < 400) begin @(posedge clk); #1; k++; end
    check_eq({tag, "_pass_timeout"}, {16'd0, pass_cnt}, {16'd0, n});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_strobes_req"}, {23'd0, gen_init, gen_save, gen_restore, gen_next,
             mem_req, mem_we, busy, phase, err_flag}, 32'd0);
    check_eq({tag, "_counts"}, {14'd0, pass_cnt, err_cnt}, 32'd0);
    check_eq({tag, "_addr_wdata"}, {11'd0, mem_addr, err_addr, dbg_state, mem_wdata}, 32'd0);
  endtask

  initial begin
    int cyc, base_wr, base_acks, base_nexts, base_init;
    rst_n = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // zero-wait single pass with known write values and cycle count
    base_wr = wr_data_q.size(); base_init = n_init;
    exp_q = {16'h0000, 16'hC796, 16'hAB61, 16'h1D47};
    enable = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) enable = 1'b0;
    end while (pass_cnt != 16'd1 && cyc < 100);
    check_eq("t1_cycles", cyc, 23);
    check_eq("t1_busy_end", {31'd0, busy}, 32'd0);
    check_eq("t1_err_cnt", {30'd0, err_cnt}, 32'd0);
    check_eq("t1_init_width", n_init - base_init, INIT_CYCLES);
    check_eq("t1_nwrites", wr_data_q.size() - base_wr, 4);
    for (int i = 0; i < 4; i++) begin
      if (base_wr + i < wr_data_q.size()) begin
        check_eq($sformatf("t1_wdata%0d", i), {16'd0, wr_data_q[base_wr+i]}, {16'd0, exp_q[i]});
        check_eq($sformatf("t1_waddr%0d", i), {30'd0, wr_addr_q[base_wr+i]}, i);
      end
    end

    // corrupted readback at addresses 2 and 3
    corrupt_mask = 4'b1100;
    enable = 1'b1; @(posedge clk); #1; enable = 1'b0;
    wait_idle("t3");
    check_eq("t3_err_cnt", {30'd0, err_cnt}, 32'd2);
    check_eq("t3_err_flag", {31'd0, err_flag}, 32'd1);
    check_eq("t3_err_addr", {30'd0, err_addr}, 32'd2);
    check_eq("t3_pass_cnt", {16'd0, pass_cnt}, 32'd1);

    // every read mismatching over two chained passes
    corrupt_mask = 4'b1111; base_init = n_init;
    enable = 1'b1; @(posedge clk); #1;
    wait_pass(16'd1, "t4a");
    enable = 1'b0;
    wait_idle("t4");
    check_eq("t4_err_cnt_sat", {30'd0, err_cnt}, 32'd3);
    check_eq("t4_pass_cnt", {16'd0, pass_cnt}, 32'd2);
    check_eq("t4_err_addr", {30'd0, err_addr}, 32'd0);
    check_eq("t4_no_reinit", n_init - base_init, INIT_CYCLES);

    // random acknowledge delays over two passes
    corrupt_mask = 4'b0000; rand_en = 1'b1;
    base_acks = n_acks; base_nexts = n_nexts;
    enable = 1'b1; @(posedge clk); #1;
    wait_pass(16'd1, "t2a");
    enable = 1'b0;
    wait_idle("t2");
    check_eq("t2_err_cnt", {30'd0, err_cnt}, 32'd0);
    check_eq("t2_pass_cnt", {16'd0, pass_cnt}, 32'd2);
    check_eq("t2_acks", n_acks - base_acks, 16);
    check_eq("t2_nexts", n_nexts - base_nexts, 16);
    check_eq("t2_stability", stab_viol, 0);
    check_eq("t2_overlap", overlap, 0);

    // enable dropped during the write phase
    rand_en = 1'b0;
    enable = 1'b1; @(posedge clk); #1;
    cyc = 0;
    while (!(mem_req && mem_we && mem_addr == 2'd1) && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check_eq("t5_reach_wr1", {31'd0, mem_req && mem_we}, 32'd1);
    enable = 1'b0;
    wait_idle("t5");
    check_eq("t5_pass_cnt", {16'd0, pass_cnt}, 32'd1);
    check_eq("t5_state_idle", {29'd0, dbg_state}, 32'd0);
    enable = 1'b1; @(posedge clk); #1;
    check_eq("t5_restart_cnt", {16'd0, pass_cnt}, 32'd0);
    check_eq("t5_restart_init", {31'd0, gen_init}, 32'd1);

    // asynchronous reset while a read request is outstanding
    cyc = 0;
    while (!(mem_req && phase) && cyc < 100) begin @(posedge clk); #1; cyc++; end
    ack_hold = 1'b1;
    @(posedge clk); #2;
    check_eq("t6_req_held", {31'd0, mem_req && !mem_we}, 32'd1);
    rst_n = 1'b0; enable = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; ack_hold = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("t6_stay_idle", {28'd0, busy, dbg_state}, 32'd0);
    enable = 1'b1; @(posedge clk); #1;
    check_eq("t6_reinit", {31'd0, gen_init}, 32'd1);
    enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
